// File: rtl/cache_refill_ctrl_if.sv
// Bundle of miss, memory-read and cache-fill signals between the refill engine and its neighbours.
// The master modport is the refill engine; the slave modport is the datapath/memory side.
interface cache_refill_ctrl_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic              miss_valid;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              tag_we;
  logic [ADDR_W-1:0] tag_addr;
  logic              refill_done;
  logic              refill_err;
  logic              busy;

  modport master (
    input  miss_valid, miss_addr, mem_ack, mem_rdata,
    output miss_ready, mem_req, mem_addr, fill_we, fill_addr, fill_data,
           tag_we, tag_addr, refill_done, refill_err, busy
  );

  modport slave (
    output miss_valid, miss_addr, mem_ack, mem_rdata,
    input  miss_ready, mem_req, mem_addr, fill_we, fill_addr, fill_data,
           tag_we, tag_addr, refill_done, refill_err, busy
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill engine: fetches a whole line word by word over req/ack,
// streams words into the data array, then commits the tag; a per-word timeout aborts.
module cache_refill_ctrl #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_refill_ctrl_if.master   bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_COMMIT, S_DONE, S_ERR} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_base;
  logic [OFF_W-1:0]    r_cnt;
  logic [7:0]          r_to;
  logic                r_fill_we;
  logic [ADDR_W-1:0]   r_fill_addr;
  logic [DATA_W-1:0]   r_fill_data;
  logic                w_last;
  logic                w_to_hit;
  logic [ADDR_W-1:0]   w_word_addr;

  // Offset replaces the low bits of the base, so the address never carries out of the line.
  assign w_word_addr = {r_base[ADDR_W-1:OFF_W], r_cnt};
  assign w_last      = (r_cnt == OFF_W'(LINE_WORDS - 1));
  assign w_to_hit    = (r_to == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.miss_valid) w_next = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ack) begin
          if (w_last) w_next = S_COMMIT;
        end else if (w_to_hit) begin
          w_next = S_ERR;
        end
      end
      S_COMMIT: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Line base, word/timeout counters and the one-cycle-delayed fill write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base      <= '0;
      r_cnt       <= '0;
      r_to        <= '0;
      r_fill_we   <= 1'b0;
      r_fill_addr <= '0;
      r_fill_data <= '0;
    end else begin
      r_fill_we <= 1'b0;
      if (r_state == S_IDLE) begin
        if (bus.miss_valid) begin
          r_base <= {bus.miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          r_cnt  <= '0;
          r_to   <= '0;
        end
      end else if (r_state == S_FETCH) begin
        if (bus.mem_ack) begin
          r_fill_we   <= 1'b1;
          r_fill_addr <= w_word_addr;
          r_fill_data <= bus.mem_rdata;
          r_cnt       <= r_cnt + OFF_W'(1);
          r_to        <= '0;
        end else begin
          r_to <= r_to + 8'd1;
        end
      end
    end
  end

  always_comb begin
    bus.miss_ready  = (r_state == S_IDLE);
    bus.busy        = (r_state != S_IDLE);
    bus.mem_req     = 1'b0;
    bus.mem_addr    = '0;
    bus.tag_we      = 1'b0;
    bus.tag_addr    = '0;
    bus.refill_done = 1'b0;
    bus.refill_err  = 1'b0;
    bus.fill_we     = r_fill_we;
    bus.fill_addr   = r_fill_addr;
    bus.fill_data   = r_fill_data;
    case (r_state)
      S_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = w_word_addr;
      end
      S_COMMIT: begin
        bus.tag_we   = 1'b1;
        bus.tag_addr = r_base;
      end
      S_DONE:  bus.refill_done = 1'b1;
      S_ERR:   bus.refill_err  = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: a cycle table for the minimum-latency refill
// plus hand-written stall, timeout, reset-abort and line-boundary sequences.
module tb_cache_refill_ctrl;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int LW     = 4;
  localparam int TO     = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cache_refill_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cache_refill_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [14:0] fa_q[$];
  logic [31:0] fd_q[$];
  int          n_tag  = 0;
  int          n_done = 0;
  int          n_err  = 0;

  // Passive monitor of the write-side strobes.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.fill_we) begin
        fa_q.push_back(bus.fill_addr);
        fd_q.push_back(bus.fill_data);
      end
      if (bus.tag_we)      n_tag  = n_tag + 1;
      if (bus.refill_done) n_done = n_done + 1;
      if (bus.refill_err)  n_err  = n_err + 1;
    end
  end

  typedef struct packed {
    logic        mv;
    logic [14:0] ma;
    logic        ack;
    logic [31:0] rd;
    logic        rdy;
    logic        req;
    logic [14:0] maddr;
    logic        fwe;
    logic [14:0] faddr;
    logic [31:0] fdata;
    logic        twe;
    logic [14:0] taddr;
    logic        done;
    logic        err;
  } vec_t;

  function automatic vec_t mk(logic mv, logic [14:0] ma, logic ack, logic [31:0] rd,
                              logic rdy, logic req, logic [14:0] maddr,
                              logic fwe, logic [14:0] faddr, logic [31:0] fdata,
                              logic twe, logic [14:0] taddr, logic done, logic err);
    vec_t v;
    v.mv = mv; v.ma = ma; v.ack = ack; v.rd = rd;
    v.rdy = rdy; v.req = req; v.maddr = maddr;
    v.fwe = fwe; v.faddr = faddr; v.fdata = fdata;
    v.twe = twe; v.taddr = taddr; v.done = done; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_refill(input logic [14:0] addr, input int stall, input int nack,
                            input logic [31:0] dbase, input bit poke);
    logic [14:0] base;
    logic [14:0] ea;
    int f0, t0, d0, e0, nf, exp_f;
    bit stop;
    base = addr & 15'h7FFC;
    f0 = fa_q.size(); t0 = n_tag; d0 = n_done; e0 = n_err;
    stop = 1'b0;
    chk("start_ready", bus.miss_ready, 1);
    bus.miss_valid = 1'b1;
    bus.miss_addr  = addr;
    cyc();
    bus.miss_valid = 1'b0;
    for (int w = 0; w < LW; w++) begin
      if (!stop) begin
        ea = base + 15'(w);
        if (w < nack) begin
          for (int c = 0; c <= stall; c++) begin
            chk("fetch_req_addr", {bus.mem_req, bus.mem_addr}, {1'b1, ea});
            if (poke && w == 1 && c == 0) begin
              bus.miss_valid = 1'b1;
              bus.miss_addr  = 15'h5555;
            end
            if (c == stall) begin
              bus.mem_ack   = 1'b1;
              bus.mem_rdata = dbase + 32'(w);
            end
            cyc();
            bus.mem_ack    = 1'b0;
            bus.miss_valid = 1'b0;
          end
        end else begin
          for (int c = 0; c < TO; c++) begin
            chk("stall_req_addr", {bus.mem_req, bus.mem_addr}, {1'b1, ea});
            cyc();
          end
          chk("timeout_err", {bus.refill_err, bus.mem_req}, 2'b10);
          cyc();
          chk("after_err_ready", {bus.miss_ready, bus.refill_err}, 2'b10);
          stop = 1'b1;
        end
      end
    end
    if (nack >= LW) begin
      chk("commit_tag", {bus.tag_we, bus.tag_addr, bus.mem_req}, {1'b1, base, 1'b0});
      cyc();
      chk("done_pulse", {bus.refill_done, bus.tag_we}, 2'b10);
      cyc();
      chk("back_idle", {bus.miss_ready, bus.busy, bus.refill_done}, 3'b100);
    end
    exp_f = (nack < LW) ? nack : LW;
    nf = fa_q.size() - f0;
    chk("fill_count", nf, exp_f);
    for (int k = 0; k < exp_f; k++) begin
      if (k < nf) begin
        chk("fill_addr", fa_q[f0 + k], base + 15'(k));
        chk("fill_data", fd_q[f0 + k], dbase + 32'(k));
      end
    end
    chk("tag_count",  n_tag  - t0, (nack >= LW) ? 1 : 0);
    chk("done_count", n_done - d0, (nack >= LW) ? 1 : 0);
    chk("err_count",  n_err  - e0, (nack >= LW) ? 0 : 1);
  endtask

  vec_t vec[9];

  initial begin
    int t0, f0;
    vec[0] = mk(1, 15'h0001, 0, 32'h0,  1, 0, 15'h0, 0, 15'h0, 32'h0,  0, 15'h0, 0, 0);
    vec[1] = mk(0, 15'h0,    1, 32'hA0, 0, 1, 15'h0, 0, 15'h0, 32'h0,  0, 15'h0, 0, 0);
    vec[2] = mk(0, 15'h0,    1, 32'hA1, 0, 1, 15'h1, 1, 15'h0, 32'hA0, 0, 15'h0, 0, 0);
    vec[3] = mk(0, 15'h0,    1, 32'hA2, 0, 1, 15'h2, 1, 15'h1, 32'hA1, 0, 15'h0, 0, 0);
    vec[4] = mk(0, 15'h0,    1, 32'hA3, 0, 1, 15'h3, 1, 15'h2, 32'hA2, 0, 15'h0, 0, 0);
    vec[5] = mk(0, 15'h0,    0, 32'h0,  0, 0, 15'h0, 1, 15'h3, 32'hA3, 1, 15'h0, 0, 0);
    vec[6] = mk(0, 15'h0,    0, 32'h0,  0, 0, 15'h0, 0, 15'h0, 32'h0,  0, 15'h0, 1, 0);
    vec[7] = mk(0, 15'h0,    1, 32'hEE, 1, 0, 15'h0, 0, 15'h0, 32'h0,  0, 15'h0, 0, 0);
    vec[8] = mk(0, 15'h0,    0, 32'h0,  1, 0, 15'h0, 0, 15'h0, 32'h0,  0, 15'h0, 0, 0);

    bus.miss_valid = 1'b0;
    bus.miss_addr  = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    rst = 1'b0;
    cyc();
    cyc();
    chk("reset_ctrl", {bus.miss_ready, bus.busy, bus.mem_req, bus.fill_we, bus.tag_we,
                       bus.refill_done, bus.refill_err}, 7'b1000000);
    chk("reset_addr", {bus.mem_addr, bus.fill_addr, bus.tag_addr}, 45'h0);
    chk("reset_data", bus.fill_data, 32'h0);
    rst = 1'b1;
    cyc();

    for (int i = 0; i < 9; i++) begin
      chk($sformatf("v%0d_ready_busy", i), {bus.miss_ready, bus.busy}, {vec[i].rdy, ~vec[i].rdy});
      chk($sformatf("v%0d_req", i), bus.mem_req, vec[i].req);
      if (vec[i].req) chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vec[i].maddr);
      chk($sformatf("v%0d_fill_we", i), bus.fill_we, vec[i].fwe);
      if (vec[i].fwe) chk($sformatf("v%0d_fill", i), {bus.fill_addr, bus.fill_data},
                          {vec[i].faddr, vec[i].fdata});
      chk($sformatf("v%0d_tag_we", i), bus.tag_we, vec[i].twe);
      if (vec[i].twe) chk($sformatf("v%0d_tag_addr", i), bus.tag_addr, vec[i].taddr);
      chk($sformatf("v%0d_done_err", i), {bus.refill_done, bus.refill_err},
          {vec[i].done, vec[i].err});
      bus.miss_valid = vec[i].mv;
      bus.miss_addr  = vec[i].ma;
      bus.mem_ack    = vec[i].ack;
      bus.mem_rdata  = vec[i].rd;
      cyc();
    end
    bus.mem_ack = 1'b0;

    // Stalled memory, with a stray miss_valid pulse while busy.
    run_refill(15'h0800, 3, 4, 32'hD0, 1'b1);
    cyc();
    chk("stray_miss_ignored", {bus.miss_ready, bus.mem_req}, 2'b10);

    // Timeout after two words.
    run_refill(15'h1234, 0, 2, 32'hE0, 1'b0);

    // Asynchronous reset in the middle of a refill.
    t0 = n_tag;
    f0 = fa_q.size();
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 15'h0020;
    cyc();
    bus.miss_valid = 1'b0;
    bus.mem_ack    = 1'b1;
    bus.mem_rdata  = 32'hB0;
    cyc();
    bus.mem_rdata  = 32'hB1;
    cyc();
    bus.mem_ack    = 1'b0;
    chk("pre_reset_fill", {bus.fill_we, bus.fill_addr}, {1'b1, 15'h0021});
    rst = 1'b0;
    #1;
    chk("midrst_ctrl", {bus.miss_ready, bus.busy, bus.mem_req, bus.fill_we, bus.tag_we,
                        bus.refill_done, bus.refill_err}, 7'b1000000);
    chk("midrst_addr", {bus.mem_addr, bus.fill_addr, bus.tag_addr}, 45'h0);
    chk("midrst_data", bus.fill_data, 32'h0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_no_tag", n_tag - t0, 0);
    chk("midrst_fills", fa_q.size() - f0, 1);
    run_refill(15'h0010, 0, 4, 32'hC0, 1'b0);

    // Top-of-memory line.
    run_refill(15'h7FFF, 0, 4, 32'hF0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
